// File: rtl/risc16_pkg.sv
// -----------------------------------------------------------------------------
// risc16_pkg
//   Shared constants and types for the RISC-16 instruction-fetch front end.
//   - RISC16_ADDR_W   : PC / instruction-memory word-address width
//   - RISC16_INSTR_W  : instruction word width
//   - RISC16_RESET_PC : first fetch address after reset
//   - fetch_entry_t   : {pc, instr} pair handed from fetch to decode
// -----------------------------------------------------------------------------
package risc16_pkg;

   localparam int RISC16_ADDR_W  = 16;
   localparam int RISC16_INSTR_W = 16;

   localparam logic [RISC16_ADDR_W-1:0] RISC16_RESET_PC = 16'h0000;

   typedef struct packed {
      logic [RISC16_ADDR_W-1:0]  pc;
      logic [RISC16_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/risc16_sync_fifo.sv
// -----------------------------------------------------------------------------
// risc16_sync_fifo
//   Single-clock FIFO of DEPTH entries of WIDTH bits with a synchronous flush.
//   The head entry is read straight from the storage array at the read
//   pointer, so head_data is a pure function of registers.
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-low reset
//   flush      in   drop all entries (wins over push/pop in the same cycle)
//   push       in   write push_data at the tail
//   push_data  in   WIDTH-bit write data
//   pop        in   remove the head entry (ignored when empty)
//   head_data  out  current head entry
//   count      out  number of stored entries, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; any other push into a full FIFO is an overflow and is flagged by an
// assertion.
// -----------------------------------------------------------------------------
module risc16_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push_en;
   logic             pop_en;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign pop_en  = pop && !empty;
   assign push_en = push && (!full || pop_en);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_en) begin
            mem[wr_ptr_q] <= push_data;
            wr_ptr_q      <= wr_ptr_q + AW'(1);
         end
         if (pop_en) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push_en, pop_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_data = mem[rd_ptr_q];
   assign count     = count_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && full && !pop_en && !flush));

endmodule

// File: rtl/risc16_fetch_unit.sv
// -----------------------------------------------------------------------------
// risc16_fetch_unit
//   Instruction-fetch front end of the RISC-16 core. Issues word addresses to
//   instruction memory, buffers in-order responses in a DEPTH-entry prefetch
//   queue and presents {pc, instr} to decode. A redirect (taken BEQ / JALR)
//   flushes everything and restarts fetch at redirect_pc; responses that
//   belong to requests issued before the redirect are discarded.
// Ports
//   clk, rst                       clock (rising edge), async active-low reset
//   imem_req_valid/ready/addr      fetch request channel to imem
//   imem_rsp_valid/data            in-order fetch responses, latency >= 1
//   redirect_valid/pc              restart fetch at redirect_pc
//   if_valid/ready/pc/instr        head of the prefetch queue to decode
// Handshake rule for both request and if_* channels: a transfer happens on a
// rising edge where valid && ready are both 1; once valid is raised the
// payload is held stable until that transfer (a redirect may still withdraw
// imem_req_valid, since it cancels the fetch stream). imem_rsp has no ready:
// it is always accepted.
// Credit: a request is only issued while queued + outstanding < DEPTH, so
// every response has a queue slot waiting for it.
// -----------------------------------------------------------------------------
module risc16_fetch_unit
   import risc16_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = RISC16_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RISC16_RESET_PC)
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic                      imem_req_valid,
   input  logic                      imem_req_ready,
   output logic [ADDR_W-1:0]         imem_req_addr,
   input  logic                      imem_rsp_valid,
   input  logic [RISC16_INSTR_W-1:0] imem_rsp_data,
   input  logic                      redirect_valid,
   input  logic [ADDR_W-1:0]         redirect_pc,
   output logic                      if_valid,
   input  logic                      if_ready,
   output logic [ADDR_W-1:0]         if_pc,
   output logic [RISC16_INSTR_W-1:0] if_instr
);

   localparam int CW      = $clog2(DEPTH) + 1;
   localparam int ENTRY_W = ADDR_W + RISC16_INSTR_W;

   logic [ADDR_W-1:0]  fetch_pc_q;
   logic [CW-1:0]      outstanding_q;
   logic [CW-1:0]      outstanding_d;
   logic [CW-1:0]      drop_cnt_q;
   logic [CW-1:0]      drop_cnt_d;
   logic               started_q;

   logic [CW-1:0]      q_count;
   logic               q_full;
   logic               q_empty;
   logic [ENTRY_W-1:0] q_head;

   logic [ADDR_W-1:0]  tag_pc;
   logic [CW-1:0]      tag_count;
   logic               tag_full;
   logic               tag_empty;

   logic [CW:0]        in_use;
   logic               credit_ok;
   logic               req_fire;
   logic               rsp_drop;
   logic               rsp_accept;
   logic               if_fire;
   logic               unused_fifo_status;

   // ---------------------------------------------------------------- request
   assign in_use    = {1'b0, q_count} + {1'b0, outstanding_q};
   assign credit_ok = (in_use < (CW+1)'(DEPTH));

   // started_q holds requests off during the cycle reset is released, so the
   // first request appears in the first full cycle after reset.
   assign imem_req_valid = started_q && credit_ok && !tag_full && !redirect_valid;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // --------------------------------------------------------------- response
   // A response arriving in the redirect cycle belongs to the old stream.
   assign rsp_drop   = imem_rsp_valid && ((drop_cnt_q != '0) || redirect_valid);
   assign rsp_accept = imem_rsp_valid && !rsp_drop && !tag_empty;
   assign if_fire    = if_valid && if_ready;

   always_comb begin
      outstanding_d = outstanding_q;
      if (req_fire && !imem_rsp_valid) begin
         outstanding_d = outstanding_q + CW'(1);
      end else if (!req_fire && imem_rsp_valid) begin
         outstanding_d = outstanding_q - CW'(1);
      end

      // No request fires in a redirect cycle, so outstanding_d there is
      // exactly the set of old-stream responses still to come: drop them all.
      drop_cnt_d = drop_cnt_q;
      if (redirect_valid) begin
         drop_cnt_d = outstanding_d;
      end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         started_q     <= 1'b0;
      end else begin
         started_q     <= 1'b1;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         if (redirect_valid) begin
            fetch_pc_q <= redirect_pc;
         end else if (req_fire) begin
            fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
         end
      end
   end

   // ------------------------------------------------------ request PC tags
   // One tag per live request, popped by the matching response, so the PC
   // paired with each instruction is the address that fetched it.
   risc16_sync_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (req_fire),
      .push_data (fetch_pc_q),
      .pop       (rsp_accept),
      .head_data (tag_pc),
      .count     (tag_count),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   // --------------------------------------------------------- prefetch queue
   // A redirect coinciding with an if handshake flushes the queue; the head
   // (the branch itself) has been taken by decode on that same edge.
   risc16_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_prefetch_q (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (rsp_accept),
      .push_data ({tag_pc, imem_rsp_data}),
      .pop       (if_fire),
      .head_data (q_head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   assign if_valid = !q_empty;
   assign if_pc    = q_head[ENTRY_W-1 -: ADDR_W];
   assign if_instr = q_head[RISC16_INSTR_W-1:0];

   assign unused_fifo_status = ^{tag_count, q_full};

endmodule
